// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl -- trap / CSR-write sequencer in front of the machine-mode CSR file.
//
// Owns the CSR file's single write port. In IDLE it arbitrates
// exception > interrupt > mret > CSR instruction (one accept per cycle).
// A trap runs a read mtvec / read mstatus / write mepc, mcause, mtval, mstatus
// sequence. An mret runs read mepc / read mstatus / write mstatus. Both end
// with a one-cycle redirect + flush to the front end.
//
// Optional feature macro: CSR_TRAP_IRQ_EN
//   defined   : irq_v_i takes part in arbitration and vectored mtvec is honoured.
//   undefined : irq_v_i/irq_pc_i are ignored and every trap goes to mtvec & ~3.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-high reset
//   exc_v_i/cause/pc/tval, exc_ready_o   exception request handshake
//   mret_v_i, mret_ready_o           mret request handshake
//   irq_v_i, irq_pc_i                timer interrupt request and resume PC
//   inst_v_i/adr/data, inst_ready_o  CSR instruction write request
//   csr_radr_o, csr_rdata_i          CSR file read port (combinational data)
//   csr_we_o, csr_wadr_o, csr_wdata_o    CSR file write port
//   redirect_v_o, redirect_pc_o      one-cycle redirect and flush
//   busy_o                           sequencer not in IDLE
module csr_trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_v_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    output logic            exc_ready_o,
    input  logic            mret_v_i,
    output logic            mret_ready_o,
    input  logic            irq_v_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            inst_v_i,
    input  logic [11:0]     inst_adr_i,
    input  logic [XLEN-1:0] inst_data_i,
    output logic            inst_ready_o,
    output logic [11:0]     csr_radr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_wadr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            redirect_v_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_TVEC, S_RD_STATUS, S_W_EPC, S_W_CAUSE, S_W_TVAL,
        S_W_STATUS, S_M_RD_EPC, S_M_RD_STATUS, S_M_W_STATUS, S_REDIR
    } state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_cause, r_pc, r_tval, r_status, r_tgt;

    // Accept logic. Readies are held low while reset is asserted so that
    // every output reads 0 during reset.
    logic w_idle, w_irq_req, w_exc_acc, w_irq_acc, w_mret_acc, w_inst_acc;
    assign w_idle = (r_state == S_IDLE) & ~rst_n;

`ifdef CSR_TRAP_IRQ_EN
    assign w_irq_req = irq_v_i;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_v_i, irq_pc_i};
    assign w_irq_req    = 1'b0;
`endif

    assign w_exc_acc  = w_idle & exc_v_i;
    assign w_irq_acc  = w_idle & ~exc_v_i & w_irq_req;
    assign w_mret_acc = w_idle & ~exc_v_i & ~w_irq_req & mret_v_i;
    assign w_inst_acc = w_idle & ~exc_v_i & ~w_irq_req & ~mret_v_i & inst_v_i;

    // Trap target from the mtvec value on the read bus during RD_TVEC.
    logic [XLEN-1:0] w_tbase, w_ttgt;
    assign w_tbase = csr_rdata_i & ~XLEN'(3);
`ifdef CSR_TRAP_IRQ_EN
    // Vectored only for interrupts with mode 1; modes 2/3 fall back to direct.
    // 4*cause[XLEN-2:0] modulo 2^XLEN drops the top two cause bits.
    assign w_ttgt = (csr_rdata_i[1:0] == 2'b01 && r_cause[XLEN-1])
                  ? w_tbase + {r_cause[XLEN-3:0], 2'b00} : w_tbase;
`else
    assign w_ttgt = w_tbase;
`endif

    // mstatus images written on trap entry and on mret.
    logic [XLEN-1:0] w_st_trap, w_st_mret;
    always_comb begin
        w_st_trap        = r_status;
        w_st_trap[7]     = r_status[3];
        w_st_trap[3]     = 1'b0;
        w_st_trap[12:11] = 2'b11;
        w_st_mret        = r_status;
        w_st_mret[3]     = r_status[7];
        w_st_mret[7]     = 1'b1;
        w_st_mret[12:11] = 2'b11;
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_exc_acc | w_irq_acc) w_next = S_RD_TVEC;
                else if (w_mret_acc)       w_next = S_M_RD_EPC;
            end
            S_RD_TVEC:     w_next = S_RD_STATUS;
            S_RD_STATUS:   w_next = S_W_EPC;
            S_W_EPC:       w_next = S_W_CAUSE;
            S_W_CAUSE:     w_next = S_W_TVAL;
            S_W_TVAL:      w_next = S_W_STATUS;
            S_W_STATUS:    w_next = S_REDIR;
            S_M_RD_EPC:    w_next = S_M_RD_STATUS;
            S_M_RD_STATUS: w_next = S_M_W_STATUS;
            S_M_W_STATUS:  w_next = S_REDIR;
            S_REDIR:       w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    // Latched trap fields, mstatus snapshot and redirect target.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cause  <= '0;
            r_pc     <= '0;
            r_tval   <= '0;
            r_status <= '0;
            r_tgt    <= '0;
        end else begin
            if (w_exc_acc) begin
                r_cause <= exc_cause_i;
                r_pc    <= exc_pc_i;
                r_tval  <= exc_tval_i;
            end
`ifdef CSR_TRAP_IRQ_EN
            else if (w_irq_acc) begin
                r_cause <= {1'b1, {(XLEN-4){1'b0}}, 3'd7};
                r_pc    <= irq_pc_i;
                r_tval  <= '0;
            end
`endif
            case (r_state)
                S_RD_TVEC:                  r_tgt    <= w_ttgt;
                S_M_RD_EPC:                 r_tgt    <= csr_rdata_i & ~XLEN'(3);
                S_RD_STATUS, S_M_RD_STATUS: r_status <= csr_rdata_i;
                default: ;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        exc_ready_o   = w_exc_acc;
        mret_ready_o  = w_mret_acc;
        inst_ready_o  = w_inst_acc;
        csr_radr_o    = '0;
        csr_we_o      = 1'b0;
        csr_wadr_o    = '0;
        csr_wdata_o   = '0;
        redirect_v_o  = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (w_inst_acc) begin
                csr_we_o    = 1'b1;
                csr_wadr_o  = inst_adr_i;
                csr_wdata_o = inst_data_i;
            end
            S_RD_TVEC:                  csr_radr_o = A_MTVEC;
            S_RD_STATUS, S_M_RD_STATUS: csr_radr_o = A_MSTATUS;
            S_M_RD_EPC:                 csr_radr_o = A_MEPC;
            S_W_EPC:      begin csr_we_o = 1'b1; csr_wadr_o = A_MEPC;    csr_wdata_o = r_pc & ~XLEN'(3); end
            S_W_CAUSE:    begin csr_we_o = 1'b1; csr_wadr_o = A_MCAUSE;  csr_wdata_o = r_cause;          end
            S_W_TVAL:     begin csr_we_o = 1'b1; csr_wadr_o = A_MTVAL;   csr_wdata_o = r_tval;           end
            S_W_STATUS:   begin csr_we_o = 1'b1; csr_wadr_o = A_MSTATUS; csr_wdata_o = w_st_trap;        end
            S_M_W_STATUS: begin csr_we_o = 1'b1; csr_wadr_o = A_MSTATUS; csr_wdata_o = w_st_mret;        end
            S_REDIR: begin
                redirect_v_o  = 1'b1;
                redirect_pc_o = r_tgt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl. Expected CSR writes and redirects are
// queued with their absolute cycle numbers when a request is driven; a
// negedge monitor pops and checks them against what the DUT produces.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exc_v_i = 1'b0, mret_v_i = 1'b0, irq_v_i = 1'b0, inst_v_i = 1'b0;
    logic [31:0] exc_cause_i = '0, exc_pc_i = '0, exc_tval_i = '0, irq_pc_i = '0;
    logic [11:0] inst_adr_i = '0;
    logic [31:0] inst_data_i = '0;
    logic        exc_ready_o, mret_ready_o, inst_ready_o;
    logic [11:0] csr_radr_o, csr_wadr_o;
    logic [31:0] csr_rdata_i, csr_wdata_o, redirect_pc_o;
    logic        csr_we_o, redirect_v_o, busy_o;

    // Readable CSR values seen by the sequencer.
    logic [31:0] m_status = '0, m_tvec = '0, m_epc = '0;

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_v_i(exc_v_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .exc_ready_o(exc_ready_o),
        .mret_v_i(mret_v_i), .mret_ready_o(mret_ready_o),
        .irq_v_i(irq_v_i), .irq_pc_i(irq_pc_i),
        .inst_v_i(inst_v_i), .inst_adr_i(inst_adr_i), .inst_data_i(inst_data_i),
        .inst_ready_o(inst_ready_o),
        .csr_radr_o(csr_radr_o), .csr_rdata_i(csr_rdata_i),
        .csr_we_o(csr_we_o), .csr_wadr_o(csr_wadr_o), .csr_wdata_o(csr_wdata_o),
        .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (csr_radr_o)
            12'h300: csr_rdata_i = m_status;
            12'h305: csr_rdata_i = m_tvec;
            12'h341: csr_rdata_i = m_epc;
            default: csr_rdata_i = 32'h0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        redir;
        logic [11:0] adr;
        logic [31:0] data;
    } ev_t;
    ev_t sb[$];
    int  ncmp = 0, nerr = 0;

    task automatic push_w(input int c, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.c = c; e.redir = 1'b0; e.adr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_r(input int c, input logic [31:0] pc);
        ev_t e;
        e.c = c; e.redir = 1'b1; e.adr = 12'h0; e.data = pc;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: any write/redirect, or any due expected event, is one comparison
    // of {cycle, kind, addr, data}.
    always @(negedge clk) begin
        logic [77:0] obs, exp;
        ev_t e;
        if (csr_we_o || redirect_v_o || (sb.size() > 0 && sb[0].c <= cyc)) begin
            obs = {cyc, csr_we_o, redirect_v_o,
                   redirect_v_o ? 12'h0 : csr_wadr_o,
                   redirect_v_o ? redirect_pc_o : csr_wdata_o};
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                exp = {e.c, ~e.redir, e.redir, e.adr, e.data};
            end else begin
                exp = {32'hFFFF_FFFF, 2'b00, 12'h0, 32'h0};
            end
            ncmp++;
            assert (obs === exp) else begin
                nerr++;
                $error("FAIL event: got cyc=%0d we/rd=%b adr=%h data=%h want cyc=%0d we/rd=%b adr=%h data=%h",
                       obs[77:46], obs[45:44], obs[43:32], obs[31:0],
                       exp[77:46], exp[45:44], exp[43:32], exp[31:0]);
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() > 0; i++) step();
        chk({tag, "_drain"}, sb.size(), 0);
        step(); step();
    endtask

    task automatic trap_exp(input int t, input logic [31:0] epc, input logic [31:0] cause,
                            input logic [31:0] tval, input logic [31:0] st, input logic [31:0] tgt);
        push_w(t + 3, 12'h341, epc);
        push_w(t + 4, 12'h342, cause);
        push_w(t + 5, 12'h343, tval);
        push_w(t + 6, 12'h300, st);
        push_r(t + 7, tgt);
    endtask

    initial begin
        int t;
        // Reset held: every output reads 0.
        step(); step();
        chk("rst_busy", busy_o, 0);
        chk("rst_we", csr_we_o, 0);
        chk("rst_redir", redirect_v_o, 0);
        chk("rst_radr", csr_radr_o, 0);
        chk("rst_readies", {exc_ready_o, mret_ready_o, inst_ready_o}, 0);
        rst_n = 1'b0;
        step();
        chk("idle_busy", busy_o, 0);
        chk("idle_wdata", csr_wdata_o, 0);

        // CSR instruction write in the accept cycle.
        inst_v_i = 1'b1; inst_adr_i = 12'h340; inst_data_i = 32'hDEAD_BEEF;
        push_w(cyc, 12'h340, 32'hDEAD_BEEF);
        #1 chk("inst_ready", inst_ready_o, 1);
        step();
        inst_v_i = 1'b0;
        drain("inst");

        // Exception, direct mode.
        m_tvec = 32'h8000_0100; m_status = 32'h8; m_epc = 32'h2000;
        exc_v_i = 1'b1; exc_cause_i = 32'd2; exc_pc_i = 32'h1006; exc_tval_i = 32'h13;
        t = cyc;
        trap_exp(t, 32'h1004, 32'd2, 32'h13, 32'h1880, 32'h8000_0100);
        #1 chk("exc_ready", exc_ready_o, 1);
        step();
        exc_v_i = 1'b0;
        chk("exc_busy", busy_o, 1);
        drain("exc");

        // mret.
        m_status = 32'h1880;
        mret_v_i = 1'b1;
        t = cyc;
        push_w(t + 3, 12'h300, 32'h1888);
        push_r(t + 4, 32'h2000);
        #1 chk("mret_ready", mret_ready_o, 1);
        step();
        mret_v_i = 1'b0;
        drain("mret");

        // exc + mret + inst together: exc at T, mret at T+8, inst at T+13.
        m_status = 32'h8;
        exc_v_i = 1'b1; mret_v_i = 1'b1; inst_v_i = 1'b1;
        inst_adr_i = 12'h340; inst_data_i = 32'h1234_5678;
        t = cyc;
        trap_exp(t, 32'h1004, 32'd2, 32'h13, 32'h1880, 32'h8000_0100);
        push_w(t + 11, 12'h300, 32'h1880);
        push_r(t + 12, 32'h2000);
        push_w(t + 13, 12'h340, 32'h1234_5678);
        #1 chk("all3_ready_T", {exc_ready_o, mret_ready_o, inst_ready_o}, 3'b100);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) exc_v_i = 1'b0;
            if (k == 9) mret_v_i = 1'b0;
            #1;
            chk($sformatf("all3_mret_rdy_%0d", k), mret_ready_o, (k == 8) ? 1 : 0);
            chk($sformatf("all3_inst_rdy_%0d", k), inst_ready_o, 0);
        end
        step();
        #1 chk("all3_inst_rdy_13", inst_ready_o, 1);
        step();
        inst_v_i = 1'b0;
        drain("all3");

        // Interrupt (vectored) or, without the feature, no response at all.
        m_tvec = 32'h101;
        irq_pc_i = 32'h3000;
        irq_v_i = 1'b1;
        t = cyc;
`ifdef CSR_TRAP_IRQ_EN
        trap_exp(t, 32'h3000, 32'h8000_0007, 32'h0, 32'h1880, 32'h11C);
        step();
        irq_v_i = 1'b0;
        chk("irq_busy", busy_o, 1);
`else
        for (int k = 0; k < 10; k++) begin
            step();
            chk("irq_off_busy", busy_o, 0);
        end
        irq_v_i = 1'b0;
`endif
        drain("irq");

        // Exception with mtvec mode 1 and an interrupt-flagged cause.
        exc_v_i = 1'b1; exc_cause_i = 32'h8000_0003; exc_pc_i = 32'h4000; exc_tval_i = 32'h0;
        t = cyc;
`ifdef CSR_TRAP_IRQ_EN
        trap_exp(t, 32'h4000, 32'h8000_0003, 32'h0, 32'h1880, 32'h10C);
`else
        trap_exp(t, 32'h4000, 32'h8000_0003, 32'h0, 32'h1880, 32'h100);
`endif
        step();
        exc_v_i = 1'b0;
        drain("vec");

        // Mode 2 is direct, even for an interrupt-flagged cause.
        m_tvec = 32'h8000_0202;
        exc_v_i = 1'b1;
        t = cyc;
        trap_exp(t, 32'h4000, 32'h8000_0003, 32'h0, 32'h1880, 32'h8000_0200);
        step();
        exc_v_i = 1'b0;
        drain("mode2");

        // Reset during W_CAUSE: only MEPC has been written.
        m_tvec = 32'h8000_0100;
        exc_v_i = 1'b1; exc_cause_i = 32'd2; exc_pc_i = 32'h1006; exc_tval_i = 32'h13;
        t = cyc;
        push_w(t + 3, 12'h341, 32'h1004);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) exc_v_i = 1'b0;
        end
        rst_n = 1'b1;
        #1 chk("midrst_busy", busy_o, 0);
        chk("midrst_we", csr_we_o, 0);
        step();
        rst_n = 1'b0;
        #1 chk("midrst_idle", busy_o, 0);
        for (int k = 0; k < 8; k++) step();
        chk("midrst_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and CSR-write sequencer placed in front of the machine-mode CSR file. It arbitrates the CSR file's single write port between CSR instructions and trap entry/return. It runs the multi-cycle update of mepc/mcause/mtval/mstatus on an exception, an interrupt or an mret. It then issues a one-cycle PC redirect with flush to the front end.

## Interface
- XLEN, 32, data width of CSRs and PCs
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- exc_v_i  in  1  exception request, held until accepted
- exc_cause_i  in  XLEN  exception cause code
- exc_pc_i  in  XLEN  PC of faulting instruction
- exc_tval_i  in  XLEN  trap value
- exc_ready_o  out  1  exception accepted when exc_v_i & exc_ready_o
- mret_v_i  in  1  mret request, held until accepted
- mret_ready_o  out  1  mret accept
- irq_v_i  in  1  timer interrupt pending and enabled (mstatus.MIE & mie.MTIE & mip.MTIP, computed outside)
- irq_pc_i  in  XLEN  PC to resume after the interrupt
- inst_v_i  in  1  CSR instruction write request
- inst_adr_i  in  12  CSR address
- inst_data_i  in  XLEN  value to write
- inst_ready_o  out  1  CSR instruction write accept
- csr_radr_o  out  12  CSR read address
- csr_rdata_i  in  XLEN  read data, combinational from csr_radr_o
- csr_we_o  out  1  CSR write strobe
- csr_wadr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- redirect_v_o  out  1  one-cycle redirect and flush
- redirect_pc_o  out  XLEN  target PC
- busy_o  out  1  state != IDLE

## Operation
- CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
- FSM states: IDLE, RD_TVEC, RD_STATUS, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_RD_EPC, M_RD_STATUS, M_W_STATUS, REDIR.
- IDLE arbitration priority: exception > interrupt > mret > CSR instruction. Exactly one requester is accepted per cycle.
  - The corresponding ready is high combinationally only for the winner.
  - All readies are 0 outside IDLE.
- CSR instruction accept: csr_we_o=1, csr_wadr_o=inst_adr_i, csr_wdata_o=inst_data_i in the same cycle. FSM stays in IDLE.
- Exception accept latches {cause, pc, tval}. Interrupt accept latches cause=0x8000_0007, pc=irq_pc_i, tval=0.
- Trap path, one state per cycle:
  - RD_TVEC: radr=MTVEC, latch tvec.
  - RD_STATUS: radr=MSTATUS, latch status.
  - W_EPC: write MEPC = pc & ~3.
  - W_CAUSE: write MCAUSE = cause.
  - W_TVAL: write MTVAL = tval.
  - W_STATUS: write MSTATUS = status with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=2'b11.
  - REDIR: then IDLE.
- Trap target:
  - Base = tvec & ~3.
  - If tvec[1:0]==1 and cause[XLEN-1]==1, target = base + 4*cause[XLEN-2:0].
  - Otherwise target = base.
  - tvec[1:0] of 2 or 3 is treated as direct mode.
- mret path:
  - M_RD_EPC: radr=MEPC, latch epc.
  - M_RD_STATUS: radr=MSTATUS, latch status.
  - M_W_STATUS: write MSTATUS with MIE=MPIE, MPIE=1, MPP=2'b11.
  - REDIR to epc & ~3.
- Arithmetic is modulo 2^XLEN. Vector offsets wrap silently.
- Outside write states, csr_we_o=0; csr_wadr_o and csr_wdata_o hold 0. Outside read states, csr_radr_o=0.

## Timing
- Reset values: all outputs 0, FSM in IDLE, latches 0. When rst_n falls, exc_ready_o, mret_ready_o and inst_ready_o are driven per arbitration from the first cycle.
- Reset asserted mid-sequence: FSM returns to IDLE immediately. No further CSR writes or redirect occur, and partially written CSRs are not rolled back.
- Trap latency: accept in cycle T. Writes occur at T+3..T+6. redirect_v_o is high exactly in cycle T+7. The next accept is possible at T+8.
- mret latency: accept in T, MSTATUS write at T+3, redirect at T+4.
- CSR instruction latency: write in the accept cycle, zero added latency.
- Simultaneous exc_v_i and inst_v_i: the exception wins; the instruction stalls (inst_ready_o=0) until IDLE.
- Requests arriving during busy_o are not sampled. Inputs other than the latched fields may change after accept.

## Configuration
- CSR_TRAP_IRQ_EN defined: irq_v_i participates in arbitration as specified, and vectored mode is honoured.
- CSR_TRAP_IRQ_EN undefined: irq_v_i and irq_pc_i are ignored and no interrupt path exists. All trap targets use direct mode (target = tvec & ~3) regardless of tvec[1:0].

## Test plan
- Reset: hold rst_n=1, then drop it -> all outputs 0, busy_o=0. Then inst_v_i=1, adr 0x340, data 0xDEAD_BEEF -> same-cycle write to 0x340 with that data.
- Exception with mtvec=0x8000_0100, mstatus=0x8, cause=2, pc=0x1006, tval=0x13 accepted at T:
  - writes MEPC=0x1004 at T+3, MCAUSE=2 at T+4, MTVAL=0x13 at T+5, MSTATUS=0x1880 at T+6.
  - redirect 0x8000_0100 at T+7.
- mret with mepc=0x2000 and mstatus=0x1880 -> MSTATUS=0x1888 at T+3, redirect 0x2000 at T+4.
- exc_v_i, mret_v_i and inst_v_i all high in IDLE -> only exc_ready_o=1. mret is accepted at T+8; the instruction is accepted at T+13.
- With CSR_TRAP_IRQ_EN, irq_v_i=1, mtvec=0x101 -> MCAUSE=0x8000_0007 and redirect 0x11C. Without the macro -> no response, busy_o stays 0.
- rst_n pulsed at T+4 of a trap -> no writes after T+4, no redirect, IDLE next cycle.
